// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch/jump resolution, EX/MEM register.
// Optional misaligned-target trap is enabled by defining EX_MISALIGN_TRAP_EN.
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int SQUASH_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [4:0]      ex_rs1_addr,
  input  logic [4:0]      ex_rs2_addr,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [4:0]      ex_rd_addr,
  input  logic [3:0]      ex_alu_op,
  input  logic            ex_alu_src,
  input  logic            ex_auipc,
  input  logic            ex_branch,
  input  logic [2:0]      ex_branch_type,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_mem_to_reg,
  input  logic            ex_stall,
  input  logic [4:0]      wb_fwd_rd_addr,
  input  logic            wb_fwd_reg_write,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_data,
  output logic [4:0]      mem_rd_addr,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_mem_to_reg,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef EX_MISALIGN_TRAP_EN
  ,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_pc
`endif
);

  localparam logic [1:0] SQUASH_LOAD = 2'(SQUASH_CYC);

  logic [1:0]      r_squash_cnt;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_alu_out;
  logic [XLEN-1:0] w_result;
  logic            w_taken;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic            w_live;
  logic            w_jump_or_taken;
  logic            w_misalign;
  logic            w_redirect;
  logic            w_load;

  // The MEM-stage result is younger than the WB-stage result, so it wins.
  always_comb begin
    w_fwd_rs1 = ex_rs1_data;
    if (mem_valid && mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == ex_rs1_addr))
      w_fwd_rs1 = mem_alu_result;
    else if (wb_fwd_reg_write && (wb_fwd_rd_addr != 5'd0) && (wb_fwd_rd_addr == ex_rs1_addr))
      w_fwd_rs1 = wb_fwd_data;
  end

  always_comb begin
    w_fwd_rs2 = ex_rs2_data;
    if (mem_valid && mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == ex_rs2_addr))
      w_fwd_rs2 = mem_alu_result;
    else if (wb_fwd_reg_write && (wb_fwd_rd_addr != 5'd0) && (wb_fwd_rd_addr == ex_rs2_addr))
      w_fwd_rs2 = wb_fwd_data;
  end

  assign w_op_a  = ex_auipc   ? ex_pc  : w_fwd_rs1;
  assign w_op_b  = ex_alu_src ? ex_imm : w_fwd_rs2;
  assign w_shamt = w_op_b[4:0];

  always_comb begin
    w_alu_out = '0;
    case (ex_alu_op)
      4'd0:    w_alu_out = w_op_a + w_op_b;
      4'd1:    w_alu_out = w_op_a - w_op_b;
      4'd2:    w_alu_out = w_op_a << w_shamt;
      4'd3:    w_alu_out = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      4'd4:    w_alu_out = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
      4'd5:    w_alu_out = w_op_a ^ w_op_b;
      4'd6:    w_alu_out = w_op_a >> w_shamt;
      4'd7:    w_alu_out = $unsigned($signed(w_op_a) >>> w_shamt);
      4'd8:    w_alu_out = w_op_a | w_op_b;
      4'd9:    w_alu_out = w_op_a & w_op_b;
      4'd10:   w_alu_out = w_op_b;
      default: w_alu_out = '0;
    endcase
  end

  // Jumps write the link address instead of the ALU output.
  assign w_result = (ex_jal || ex_jalr) ? (ex_pc + 32'd4) : w_alu_out;

  always_comb begin
    w_taken = 1'b0;
    case (ex_branch_type)
      3'b000:  w_taken = (w_fwd_rs1 == w_fwd_rs2);
      3'b001:  w_taken = (w_fwd_rs1 != w_fwd_rs2);
      3'b100:  w_taken = ($signed(w_fwd_rs1) <  $signed(w_fwd_rs2));
      3'b101:  w_taken = ($signed(w_fwd_rs1) >= $signed(w_fwd_rs2));
      3'b110:  w_taken = (w_fwd_rs1 <  w_fwd_rs2);
      3'b111:  w_taken = (w_fwd_rs1 >= w_fwd_rs2);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_br_target = ex_pc + ex_imm;
  assign w_jalr_sum  = w_fwd_rs1 + ex_imm;
  assign w_target    = ex_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_br_target;

  assign w_live          = ex_valid && !ex_stall && (r_squash_cnt == 2'd0);
  assign w_jump_or_taken = w_live && (ex_jal || ex_jalr || (ex_branch && w_taken));

`ifdef EX_MISALIGN_TRAP_EN
  assign w_misalign = w_jump_or_taken && w_target[1];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_redirect = w_jump_or_taken && !w_misalign;
  assign w_load     = w_live && !w_misalign;

  // Data fields load every cycle; only valid and the control bits mark a bubble.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_data       <= '0;
      mem_rd_addr    <= 5'd0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      r_squash_cnt   <= 2'd0;
`ifdef EX_MISALIGN_TRAP_EN
      misalign_exc   <= 1'b0;
      misalign_pc    <= '0;
`endif
    end else begin
      mem_valid      <= w_load;
      mem_alu_result <= w_result;
      mem_data       <= w_fwd_rs2;
      mem_rd_addr    <= ex_rd_addr;
      mem_reg_write  <= w_load && ex_reg_write && (ex_rd_addr != 5'd0);
      mem_mem_read   <= w_load && ex_mem_read;
      mem_mem_write  <= w_load && ex_mem_write;
      mem_mem_to_reg <= w_load && ex_mem_to_reg;
      redirect_valid <= w_redirect;
      if (w_redirect)
        redirect_pc <= w_target;
      // A trapped jump also squashes the wrong-path instructions behind it.
      if (w_jump_or_taken)
        r_squash_cnt <= SQUASH_LOAD;
      else if (r_squash_cnt != 2'd0)
        r_squash_cnt <= r_squash_cnt - 2'd1;
`ifdef EX_MISALIGN_TRAP_EN
      misalign_exc <= w_misalign;
      if (w_misalign)
        misalign_pc <= ex_pc;
`endif
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, reset corner cases, then random stimulus
// checked against a behavioural model. Honours EX_MISALIGN_TRAP_EN when it is defined.
module tb_ex_stage;

  localparam int SQ = 2;
`ifdef EX_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        src;
    logic        auipc;
    logic        branch;
    logic [2:0]  btype;
    logic        jal;
    logic        jalr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        stall;
    logic [4:0]  wbrd;
    logic        wbrw;
    logic [31:0] wbd;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic [31:0] res;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
    logic        trap;
    logic [31:0] tpc;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd_addr;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_auipc, ex_branch;
  logic [2:0]  ex_branch_type;
  logic        ex_jal, ex_jalr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_stall;
  logic [4:0]  wb_fwd_rd_addr;
  logic        wb_fwd_reg_write;
  logic [31:0] wb_fwd_data;
  logic        mem_valid;
  logic [31:0] mem_alu_result, mem_data;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef EX_MISALIGN_TRAP_EN
  logic        misalign_exc;
  logic [31:0] misalign_pc;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state: what the EX/MEM register should hold before the next edge.
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_res, m_rpc, m_tpc;
  int          m_kill;

  vec_t vecs[25];

  ex_stage #(.XLEN(32), .SQUASH_CYC(SQ)) dut (
    .clk(clk), .rst_(rst_),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_auipc(ex_auipc), .ex_branch(ex_branch),
    .ex_branch_type(ex_branch_type), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_stall(ex_stall),
    .wb_fwd_rd_addr(wb_fwd_rd_addr), .wb_fwd_reg_write(wb_fwd_reg_write),
    .wb_fwd_data(wb_fwd_data),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_data(mem_data),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef EX_MISALIGN_TRAP_EN
    , .misalign_exc(misalign_exc), .misalign_pc(misalign_pc)
`endif
  );

  always #5 clk = ~clk;

  function automatic stim_t mkAlu(logic [3:0] op, logic [4:0] rd, logic [4:0] rs1a, logic [31:0] rs1d,
                                  logic [4:0] rs2a, logic [31:0] rs2d, logic [31:0] imm, logic src);
    stim_t s;
    s.valid = 1'b1; s.pc = 32'h0; s.rs1a = rs1a; s.rs2a = rs2a; s.rs1d = rs1d; s.rs2d = rs2d;
    s.imm = imm; s.rd = rd; s.op = op; s.src = src; s.auipc = 1'b0; s.branch = 1'b0;
    s.btype = 3'd0; s.jal = 1'b0; s.jalr = 1'b0; s.rw = 1'b1; s.mr = 1'b0; s.mw = 1'b0;
    s.m2r = 1'b0; s.stall = 1'b0; s.wbrd = 5'd0; s.wbrw = 1'b0; s.wbd = 32'h0;
    return s;
  endfunction

  function automatic exp_t mkExp(logic valid, logic [4:0] rd, logic rw, logic mw, logic [31:0] res,
                                 logic [31:0] data, logic redir, logic [31:0] rpc);
    exp_t e;
    e.valid = valid; e.rd = rd; e.rw = rw; e.mr = 1'b0; e.mw = mw; e.m2r = 1'b0; e.res = res;
    e.data = data; e.redir = redir; e.rpc = rpc; e.trap = 1'b0; e.tpc = 32'h0;
    return e;
  endfunction

  // Drive one instruction's worth of EX inputs.
  task automatic applyStimulus(input stim_t s);
    ex_valid = s.valid; ex_pc = s.pc; ex_rs1_addr = s.rs1a; ex_rs2_addr = s.rs2a;
    ex_rs1_data = s.rs1d; ex_rs2_data = s.rs2d; ex_imm = s.imm; ex_rd_addr = s.rd;
    ex_alu_op = s.op; ex_alu_src = s.src; ex_auipc = s.auipc; ex_branch = s.branch;
    ex_branch_type = s.btype; ex_jal = s.jal; ex_jalr = s.jalr; ex_reg_write = s.rw;
    ex_mem_read = s.mr; ex_mem_write = s.mw; ex_mem_to_reg = s.m2r; ex_stall = s.stall;
    wb_fwd_rd_addr = s.wbrd; wb_fwd_reg_write = s.wbrw; wb_fwd_data = s.wbd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, expv);
    end
  endtask

  // Directed-vector check: data fields only matter when the slot is valid.
  task automatic checkVector(input string tag, input exp_t e);
    checkOutput({tag, ".valid"}, 32'(mem_valid), 32'(e.valid));
    checkOutput({tag, ".reg_write"}, 32'(mem_reg_write), 32'(e.rw));
    checkOutput({tag, ".mem_write"}, 32'(mem_mem_write), 32'(e.mw));
    checkOutput({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(e.redir));
    if (e.valid) begin
      checkOutput({tag, ".rd"}, 32'(mem_rd_addr), 32'(e.rd));
      checkOutput({tag, ".result"}, mem_alu_result, e.res);
      checkOutput({tag, ".data"}, mem_data, e.data);
    end
    if (e.redir) checkOutput({tag, ".redirect_pc"}, redirect_pc, e.rpc);
`ifdef EX_MISALIGN_TRAP_EN
    checkOutput({tag, ".misalign_exc"}, 32'(misalign_exc), 32'(e.trap));
    if (e.trap) checkOutput({tag, ".misalign_pc"}, misalign_pc, e.tpc);
`endif
  endtask

  // Random-phase check: every output against the model.
  task automatic checkFull(input int idx, input exp_t e);
    string t;
    t = $sformatf("rnd%0d", idx);
    checkVector(t, e);
    checkOutput({t, ".mem_read"}, 32'(mem_mem_read), 32'(e.mr));
    checkOutput({t, ".mem_to_reg"}, 32'(mem_mem_to_reg), 32'(e.m2r));
    checkOutput({t, ".redirect_pc_hold"}, redirect_pc, e.rpc);
`ifdef EX_MISALIGN_TRAP_EN
    checkOutput({t, ".misalign_pc_hold"}, misalign_pc, e.tpc);
`endif
  endtask

  // Reference ALU built from plain 64-bit arithmetic rather than bit operators on shifts.
  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p2, r;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    p2 = longint'(1) << (b & 32'd31);
    case (op)
      4'd0:    r = ua + ub;
      4'd1:    r = ua - ub;
      4'd2:    r = ua * p2;
      4'd3:    r = (sa < sb) ? 1 : 0;
      4'd4:    r = (ua < ub) ? 1 : 0;
      4'd5:    r = ua ^ ub;
      4'd6:    r = ua / p2;
      4'd7:    r = (sa >= 0) ? sa / p2 : -((-sa + p2 - 1) / p2);
      4'd8:    r = ua | ub;
      4'd9:    r = ua & ub;
      4'd10:   r = ub;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic refTaken(input logic [2:0] bt, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'(x); uy = longint'(y);
    case (bt)
      3'b000:  return ux == uy;
      3'b001:  return ux != uy;
      3'b100:  return sx < sy;
      3'b101:  return sx >= sy;
      3'b110:  return ux < uy;
      3'b111:  return ux >= uy;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] refFwd(input logic [4:0] addr, input logic [31:0] rf, input stim_t s);
    if (m_valid && m_rw && m_rd != 5'd0 && m_rd == addr) return m_res;
    if (s.wbrw && s.wbrd != 5'd0 && s.wbrd == addr) return s.wbd;
    return rf;
  endfunction

  task automatic modelReset();
    m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_res = 32'h0;
    m_rpc = 32'h0; m_tpc = 32'h0; m_kill = 0;
  endtask

  // Predict the outputs after the next edge and advance the model.
  task automatic modelStep(input stim_t s, output exp_t e);
    logic [31:0] f1, f2, a, b, tgt, sum;
    logic live, jumpy, trap;
    f1 = refFwd(s.rs1a, s.rs1d, s);
    f2 = refFwd(s.rs2a, s.rs2d, s);
    a  = s.auipc ? s.pc : f1;
    b  = s.src ? s.imm : f2;
    live  = s.valid && !s.stall && (m_kill == 0);
    jumpy = live && (s.jal || s.jalr || (s.branch && refTaken(s.btype, f1, f2)));
    if (s.jalr) begin
      sum = f1 + s.imm;
      tgt = sum - (sum % 2);
    end else begin
      tgt = s.pc + s.imm;
    end
    trap = TRAP && jumpy && ((tgt / 2) % 2 == 1);
    e.valid = live && !trap;
    e.rd    = s.rd;
    e.rw    = e.valid && s.rw && (s.rd != 5'd0);
    e.mr    = e.valid && s.mr;
    e.mw    = e.valid && s.mw;
    e.m2r   = e.valid && s.m2r;
    e.res   = (s.jal || s.jalr) ? s.pc + 32'd4 : refAlu(s.op, a, b);
    e.data  = f2;
    e.redir = jumpy && !trap;
    if (e.redir) m_rpc = tgt;
    e.rpc   = m_rpc;
    e.trap  = trap;
    if (trap) m_tpc = s.pc;
    e.tpc   = m_tpc;
    if (jumpy) m_kill = SQ;
    else if (m_kill > 0) m_kill--;
    m_valid = e.valid; m_rw = e.rw; m_rd = s.rd; m_res = e.res;
  endtask

  initial begin
    stim_t add3, st, nopS;
    exp_t  e;

    // Directed table: cycle-by-cycle sequence with hand-derived expectations (SQ = 2).
    add3 = mkAlu(4'd0, 5'd3, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0);
    nopS = add3; nopS.valid = 1'b0;
    vecs[0].s = add3; vecs[0].e = mkExp(1, 3, 1, 0, 32'd12, 32'd7, 0, 0);
    vecs[1].s = mkAlu(4'd0, 5'd1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd4, 1'b1);
    vecs[1].e = mkExp(1, 1, 1, 0, 32'd4, 32'd0, 0, 0);
    vecs[2].s = mkAlu(4'd0, 5'd2, 5'd1, 32'd0, 5'd1, 32'd0, 32'd0, 1'b0);
    vecs[2].e = mkExp(1, 2, 1, 0, 32'd8, 32'd4, 0, 0);
    vecs[3].s = vecs[1].s; vecs[3].e = vecs[1].e;
    vecs[4].s = nopS; vecs[4].e = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
    st = vecs[2].s; st.wbrd = 5'd1; st.wbrw = 1'b1; st.wbd = 32'd4;
    vecs[5].s = st; vecs[5].e = mkExp(1, 2, 1, 0, 32'd8, 32'd4, 0, 0);
    vecs[6].s = mkAlu(4'd0, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd9, 1'b1);
    vecs[6].e = mkExp(1, 0, 0, 0, 32'd9, 32'd0, 0, 0);
    vecs[7].s = mkAlu(4'd7, 5'd6, 5'd5, 32'h80000000, 5'd0, 32'd0, 32'd4, 1'b1);
    vecs[7].e = mkExp(1, 6, 1, 0, 32'hF8000000, 32'd0, 0, 0);
    vecs[8].s = mkAlu(4'd4, 5'd8, 5'd5, 32'd1, 5'd7, 32'hFFFFFFFF, 32'd0, 1'b0);
    vecs[8].e = mkExp(1, 8, 1, 0, 32'd1, 32'hFFFFFFFF, 0, 0);
    vecs[9].s = mkAlu(4'd3, 5'd9, 5'd5, 32'd1, 5'd7, 32'hFFFFFFFF, 32'd0, 1'b0);
    vecs[9].e = mkExp(1, 9, 1, 0, 32'd0, 32'hFFFFFFFF, 0, 0);
    st = mkAlu(4'd0, 5'd0, 5'd10, 32'h1000, 5'd9, 32'h55, 32'd8, 1'b1);
    st.rw = 1'b0; st.mw = 1'b1; st.stall = 1'b1;
    vecs[10].s = st; vecs[10].e = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[11].s = st; vecs[11].e = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
    st.stall = 1'b0; st.wbrd = 5'd9; st.wbrw = 1'b1; st.wbd = 32'hABCD;
    vecs[12].s = st; vecs[12].e = mkExp(1, 0, 0, 1, 32'h1008, 32'hABCD, 0, 0);
    st = mkAlu(4'd1, 5'd0, 5'd11, 32'd7, 5'd12, 32'd7, 32'h20, 1'b0);
    st.rw = 1'b0; st.pc = 32'h100; st.branch = 1'b1; st.btype = 3'b000;
    vecs[13].s = st; vecs[13].e = mkExp(1, 0, 0, 0, 32'd0, 32'd7, 1, 32'h120);
    vecs[14].s = add3; vecs[14].e = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[15].s = add3; vecs[15].e = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[16].s = add3; vecs[16].e = vecs[0].e;
    st = mkAlu(4'd0, 5'd1, 5'd13, 32'h203, 5'd0, 32'd0, 32'd0, 1'b1);
    st.pc = 32'h40; st.jalr = 1'b1;
    vecs[17].s = st;
`ifdef EX_MISALIGN_TRAP_EN
    vecs[17].e = mkExp(0, 1, 0, 0, 0, 0, 0, 0); vecs[17].e.trap = 1'b1; vecs[17].e.tpc = 32'h40;
`else
    vecs[17].e = mkExp(1, 1, 1, 0, 32'h44, 32'd0, 1, 32'h202);
`endif
    vecs[18].s = add3; vecs[18].e = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[19].s = add3; vecs[19].e = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
    st = vecs[13].s; st.btype = 3'b001;
    vecs[20].s = st; vecs[20].e = mkExp(1, 0, 0, 0, 32'd0, 32'd7, 0, 0);
    st = mkAlu(4'd0, 5'd1, 5'd0, 32'd0, 5'd0, 32'd0, 32'h10, 1'b1);
    st.pc = 32'h200; st.jal = 1'b1;
    vecs[21].s = st; vecs[21].e = mkExp(1, 1, 1, 0, 32'h204, 32'd0, 1, 32'h210);
    st = add3; st.stall = 1'b1;
    vecs[22].s = st; vecs[22].e = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[23].s = add3; vecs[23].e = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[24].s = add3; vecs[24].e = vecs[0].e;

    // Reset held with a valid ADD presented: everything must stay at zero.
    rst_ = 1'b1;
    applyStimulus(add3);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("reset.mem_alu_result", mem_alu_result, 32'd0);
    checkOutput("reset.mem_data", mem_data, 32'd0);
    checkOutput("reset.mem_rd_addr", 32'(mem_rd_addr), 32'd0);
    checkOutput("reset.mem_reg_write", 32'(mem_reg_write), 32'd0);
    checkOutput("reset.redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("reset.redirect_pc", redirect_pc, 32'd0);
    rst_ = 1'b0;

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].s);
      @(posedge clk);
      #1;
      checkVector($sformatf("vec%0d", i), vecs[i].e);
    end

    // Reset arriving while a redirect pulse is high clears it without a clock edge.
    st = mkAlu(4'd0, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd8, 1'b1);
    st.rw = 1'b0; st.pc = 32'h300; st.jal = 1'b1;
    applyStimulus(st);
    @(posedge clk);
    #1;
    checkOutput("midreset.redirect_before", 32'(redirect_valid), 32'd1);
    checkOutput("midreset.redirect_pc_before", redirect_pc, 32'h308);
    applyStimulus(add3);
    #2 rst_ = 1'b1;
    #1;
    checkOutput("midreset.redirect_async", 32'(redirect_valid), 32'd0);
    checkOutput("midreset.mem_valid_async", 32'(mem_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midreset.held", 32'(mem_valid), 32'd0);
    rst_ = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset.after_valid", 32'(mem_valid), 32'd1);
    checkOutput("midreset.after_result", mem_alu_result, 32'd12);

    // Random phase against the behavioural model.
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    modelReset();
    for (int i = 0; i < 400; i++) begin
      int unsigned kind;
      stim_t rs;
      rs = mkAlu(4'($urandom_range(0, 15)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom(), 5'($urandom_range(0, 3)), $urandom(), 32'd0, 1'($urandom_range(0, 1)));
      rs.imm    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom();
      rs.pc     = $urandom() & 32'hFFFF_FFFC;
      rs.valid  = ($urandom_range(0, 5) != 0);
      rs.stall  = ($urandom_range(0, 5) == 0);
      rs.auipc  = ($urandom_range(0, 7) == 0);
      rs.rw     = 1'($urandom_range(0, 1));
      rs.mr     = 1'($urandom_range(0, 1));
      rs.mw     = 1'($urandom_range(0, 1));
      rs.m2r    = 1'($urandom_range(0, 1));
      rs.wbrw   = 1'($urandom_range(0, 1));
      rs.wbrd   = 5'($urandom_range(0, 3));
      rs.wbd    = $urandom();
      rs.btype  = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 9);
      rs.jal    = (kind == 0);
      rs.jalr   = (kind == 1);
      rs.branch = (kind == 2 || kind == 3);
      applyStimulus(rs);
      modelStep(rs, e);
      @(posedge clk);
      #1;
      checkFull(i, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
